// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared op codes, FSM states and op classifiers for the MD unit
// Purpose : definitions shared by md_unit, md_calc and the controller's decoder.
// Ports   : none (package md_defs).
// Config  : MD_UNIT_MADD_EN makes MADD/MADDU/MSUB/MSUBU legal multiply-class ops.
package md_defs;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MADD  = 4'd6;
  localparam logic [3:0] MD_MADDU = 4'd7;
  localparam logic [3:0] MD_MSUB  = 4'd8;
  localparam logic [3:0] MD_MSUBU = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Single-cycle register writes: no RUN phase.
  function automatic logic md_is_mt(input logic [3:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Multiply-class ops share MULT_CYCLES latency.
  function automatic logic md_is_mult(input logic [3:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MD_UNIT_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

endpackage

// File: rtl/md_unit_calc.sv
// rtl/md_unit_calc.sv - combinational HI/LO result generator for the MD unit
// Purpose : computes the new {HI,LO} for one op from its operands and current HI/LO.
// Ports   : i_op (op code), i_a/i_b (operands), i_hi/i_lo (current HI/LO),
//           o_new_hi/o_new_lo (result), o_write_en (result must be committed).
// Config  : MD_UNIT_MADD_EN enables the accumulate ops; otherwise they produce no write.
module md_calc
  import md_defs::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_new_hi,
  output logic [31:0] o_new_lo,
  output logic        o_write_en
);

  logic [63:0] w_prod_u;
  logic [63:0] w_prod_s;
  logic        w_b_zero;
  logic [31:0] w_divu_b;
  logic [31:0] w_qu;
  logic [31:0] w_ru;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_qs_mag;
  logic [31:0] w_rs_mag;
  logic [31:0] w_qs;
  logic [31:0] w_rs;

  // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};
  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};

  // A zero divisor is replaced by 1 so the dividers never see zero; the write is suppressed below.
  assign w_b_zero = (i_b == 32'd0);
  assign w_divu_b = w_b_zero ? 32'd1 : i_b;
  assign w_qu     = i_a / w_divu_b;
  assign w_ru     = i_a % w_divu_b;

  // Signed divide on magnitudes: 0x80000000 has magnitude 0x80000000 as unsigned,
  // so the overflow case 0x80000000 / -1 naturally yields 0x80000000 rem 0.
  assign w_abs_a  = i_a[31] ? -i_a : i_a;
  assign w_abs_b  = w_b_zero ? 32'd1 : (i_b[31] ? -i_b : i_b);
  assign w_qs_mag = w_abs_a / w_abs_b;
  assign w_rs_mag = w_abs_a % w_abs_b;
  assign w_qs     = (i_a[31] ^ i_b[31]) ? -w_qs_mag : w_qs_mag;
  assign w_rs     = i_a[31] ? -w_rs_mag : w_rs_mag;

  always_comb begin
    o_new_hi   = i_hi;
    o_new_lo   = i_lo;
    o_write_en = 1'b0;
    case (i_op)
      MD_MULT: begin
        {o_new_hi, o_new_lo} = w_prod_s;
        o_write_en           = 1'b1;
      end
      MD_MULTU: begin
        {o_new_hi, o_new_lo} = w_prod_u;
        o_write_en           = 1'b1;
      end
      MD_DIV: begin
        o_new_hi   = w_rs;
        o_new_lo   = w_qs;
        o_write_en = !w_b_zero;
      end
      MD_DIVU: begin
        o_new_hi   = w_ru;
        o_new_lo   = w_qu;
        o_write_en = !w_b_zero;
      end
      MD_MTHI: begin
        o_new_hi   = i_a;
        o_write_en = 1'b1;
      end
      MD_MTLO: begin
        o_new_lo   = i_a;
        o_write_en = 1'b1;
      end
`ifdef MD_UNIT_MADD_EN
      MD_MADD: begin
        {o_new_hi, o_new_lo} = {i_hi, i_lo} + w_prod_s;
        o_write_en           = 1'b1;
      end
      MD_MADDU: begin
        {o_new_hi, o_new_lo} = {i_hi, i_lo} + w_prod_u;
        o_write_en           = 1'b1;
      end
      MD_MSUB: begin
        {o_new_hi, o_new_lo} = {i_hi, i_lo} - w_prod_s;
        o_write_en           = 1'b1;
      end
      MD_MSUBU: begin
        {o_new_hi, o_new_lo} = {i_hi, i_lo} - w_prod_u;
        o_write_en           = 1'b1;
      end
`endif
      default: begin
        o_write_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - MIPS32 multiply/divide unit holding HI/LO
// Purpose : runs MULT/MULTU/DIV/DIVU as fixed-latency ops, MTHI/MTLO in one cycle,
//           and flags busy so the controller stalls dependent instructions.
// Ports   : clk, reset (async, active low), start/op/src_a/src_b (request),
//           busy (op in flight), hi/lo (architectural HI/LO).
// Config  : MD_UNIT_MADD_EN enables MADD/MADDU/MSUB/MSUBU (MULT_CYCLES latency).
module md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             w_capture;
  logic             w_commit;
  logic [3:0]       w_calc_op;
  logic [31:0]      w_calc_a;
  logic [31:0]      w_calc_b;
  logic [31:0]      w_new_hi;
  logic [31:0]      w_new_lo;
  logic             w_calc_we;

  // In IDLE only MTHI/MTLO commit, straight from the live request; in RUN the
  // captured operands are used, with HI/LO read at commit for the accumulate ops.
  assign w_calc_op = (r_state == RUN) ? r_op : op;
  assign w_calc_a  = (r_state == RUN) ? r_a  : src_a;
  assign w_calc_b  = (r_state == RUN) ? r_b  : src_b;

  md_calc u_calc (
    .i_op       (w_calc_op),
    .i_a        (w_calc_a),
    .i_b        (w_calc_b),
    .i_hi       (r_hi),
    .i_lo       (r_lo),
    .o_new_hi   (w_new_hi),
    .o_new_lo   (w_new_lo),
    .o_write_en (w_calc_we)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (md_is_mt(op)) begin
            w_commit = 1'b1;
          end else if (md_is_mult(op) || md_is_div(op)) begin
            w_capture   = 1'b1;
            w_state_nxt = RUN;
            w_cnt_nxt   = md_is_div(op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          end
        end
      end
      RUN: begin
        // start is not looked at here: requests while busy are dropped.
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= MD_MULT;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_op <= op;
        r_a  <= src_a;
        r_b  <= src_b;
      end
      if (w_commit && w_calc_we) begin
        r_hi <= w_new_hi;
        r_lo <= w_new_lo;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the MIPS32 datapath. Consumes the two GRF read ports (rs → `src_a`, rt → `src_b`), runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations, and holds the HI/LO architectural registers. It raises `busy` so the controller can stall MFHI/MFLO and further MD instructions. HI/LO are read back into GRF write-back through `hi`/`lo`.

## Interface
- `MULT_CYCLES`, 5: busy cycles for multiply-class ops (≥1).
- `DIV_CYCLES`, 10: busy cycles for divide-class ops (≥1).
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled on the rising edge of `clk`.
- `op` input 4: operation code (see Structure).
- `src_a` input 32: rs value (GRF `read_data1`).
- `src_b` input 32: rt value (GRF `read_data2`).
- `busy` output 1: a multi-cycle op is in flight.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- States: IDLE, RUN. Down-counter `cnt` is sized for max(MULT_CYCLES, DIV_CYCLES).
- Accept: `start`=1, `busy`=0, and valid `op` at an edge. Ops with an undefined or disabled `op` are ignored.
- MTHI/MTLO: `hi` (or `lo`) ← `src_a` at the accept edge. There is no RUN and `busy` stays 0.
- MULT/MULTU: {HI,LO} ← signed/unsigned 64-bit `src_a`×`src_b`.
- DIV (signed): LO ← quotient truncated toward zero; HI ← remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero: the op still runs DIV_CYCLES, then HI/LO are left unchanged.
- Operands are captured at the accept edge. The result is computed into pending registers and is not visible on `hi`/`lo` until commit.
- IDLE→RUN: on accept of a multi-cycle op, `cnt` ← N−1 (N = MULT_CYCLES or DIV_CYCLES).
- RUN: `cnt` decrements each edge. At the edge where `cnt`=0, HI/LO ← pending and the state returns to IDLE.
- `start` while `busy`=1 is ignored; no queuing. The controller is responsible for holding the instruction.
- Asserting `reset` (low), including mid-operation: state→IDLE, `busy`=0, `hi`=`lo`=0, pending discarded, all immediately and asynchronously.

## Timing
- Reset values: `busy`=0, `hi`=0x00000000, `lo`=0x00000000.
- An op accepted at edge E0 sets `busy`=1 from just after E0 through edge E_N.
  - After E_N: `busy`=0 and the new HI/LO are visible.
  - `busy` is therefore high for exactly N cycles.
- A new `start` is accepted at the first edge where `busy` was 0, i.e. back-to-back at E_N+1.
- MTHI/MTLO: the new value is visible the cycle after the accept edge.
- `hi`/`lo`/`busy` are registered outputs; no combinational path from inputs.

## Configuration
- `MD_UNIT_MADD_EN` defined: MADD/MADDU/MSUB/MSUBU are legal.
  - {HI,LO} ← {HI,LO} ± product, modulo 2^64.
  - Signed or unsigned product per op.
  - The {HI,LO} base is read at commit, not at accept.
  - Latency is MULT_CYCLES.
- `MD_UNIT_MADD_EN` not defined: those op codes are ignored like undefined codes (no busy, no state change).

## Structure
- Shared package `md_defs` holds:
  - op codes MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5, MD_MADD=6, MD_MADDU=7, MD_MSUB=8, MD_MSUBU=9;
  - state encodings IDLE/RUN.
  - The controller's decoder uses the same constants.
- One sub-module `md_calc`: combinational 64-bit result generator (op, a, b, hi, lo → new_hi, new_lo, write_en), including the divide-by-zero suppression. `md_unit` owns the FSM, counter and registers.

## Test plan
- Reset, then MULT with 0xFFFFFFFE×0x00000003 → `busy` high exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- MULTU with 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001 after 5 cycles.
- DIV with 0xFFFFFFF9 (−7) / 2 → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Set via MTHI 0x12345678 and MTLO 0x9ABCDEF0, then DIVU by 0 → `busy` 10 cycles; `hi`/`lo` unchanged. Second `start` pulsed mid-run → ignored.
- DIVU 100/7 started, `reset` pulled low at cycle 4 → immediately `busy`=0, `hi`=`lo`=0. After release, MTLO 5 → `lo`=5 the next cycle.
- With `MD_UNIT_MADD_EN`: HI:LO=0:0xFFFFFFFF, MADDU 1×1 → `hi`=1, `lo`=0. Without it: same stimulus → `busy` stays 0 and HI/LO are unchanged.
